tt_sel_seq: RTL
===============

Name: tt_sel_seq

Overview:
- Selection sequencer that drives the chip's three design-select control lines (sel_rst_n, sel_inc, ena) from a simple address request interface.
- Sits between a host-side controller (e.g. on-board MCU bridge or test harness) and the ctrl pad inputs feeding tt_ctrl.
- Converts "select design N" into the required reset, increment-pulse and enable waveform with programmable pulse widths.
- Tracks the currently selected address and uses incremental selection when possible.

Parameters:
- ADDR_W, 10, width of the design address (mux id and block id, counted by sel_inc pulses).
- PULSE_W, 2, cycles per phase: sel_rst_n low time, each sel_inc high time, each sel_inc low time, and ena-low gap. Must be ≥1.
- SETTLE, 4, cycles sel_rst_n is held high before the first increment after a reset. Must be ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  selection request valid.
- req_addr  input  ADDR_W  target design address.
- req_ready  output  1  high in IDLE; a request is accepted on the edge where req_valid & req_ready.
- busy  output  1  high from the cycle after acceptance until the done cycle inclusive.
- done  output  1  one-cycle pulse when the target is selected and enabled.
- cur_addr  output  ADDR_W  last successfully selected address.
- cur_valid  output  1  cur_addr is meaningful.
- ctl_sel_rst_n  output  1  to pad sel_rst_n; low holds the selection counter in reset.
- ctl_sel_inc  output  1  to pad sel_inc; each rising edge increments the selection.
- ctl_ena  output  1  to pad ena; enables the selected design.

Behaviour:
- Outputs:
  - All outputs are registered.
  - Reset values: ctl_sel_rst_n=0, ctl_sel_inc=0, ctl_ena=0, busy=0, done=0, cur_addr=0, cur_valid=0, state=IDLE, so req_ready=1.
- rst has priority in any state. Reset mid-sequence:
  - abandons the request with no done;
  - drops ctl_ena and ctl_sel_inc;
  - asserts ctl_sel_rst_n=0;
  - clears cur_valid.
- FSM states: IDLE, RST, REL, GAP, INC_HI, INC_LO, ENA.
- Path selection on acceptance, with the target latched:
  - Same path: cur_valid and req_addr==cur_addr. Go to ENA next cycle. ctl_ena stays high and no pulses are issued. Latency is 1.
  - Incremental path: cur_valid and req_addr>cur_addr.
    - GAP: ctl_ena=0 for PULSE_W cycles.
    - Then (req_addr−cur_addr) increment pulses.
    - Then ENA.
  - Full path: otherwise (cold start, or req_addr<cur_addr, i.e. no wrap-around through the counter).
    - RST: ctl_sel_rst_n=0, ctl_ena=0 for PULSE_W cycles.
    - REL: ctl_sel_rst_n=1 for SETTLE cycles.
    - Then req_addr pulses.
    - Then ENA.
    - req_addr=0 gives zero pulses.
- Pulses:
  - INC_HI holds ctl_sel_inc=1 for PULSE_W cycles.
  - INC_LO holds ctl_sel_inc=0 for PULSE_W cycles.
  - The remaining-pulse counter (ADDR_W bits) decrements at the end of each INC_LO. Exit when it reaches 0.
- ENA (exactly 1 cycle):
  - ctl_ena=1, done=1, cur_addr=target, cur_valid=1.
  - Next state IDLE, where ctl_ena remains 1.
- Latency from the accept edge to the done cycle, with N = pulse count:
  - full path: PULSE_W + SETTLE + 2·PULSE_W·N + 1;
  - incremental path: PULSE_W + 2·PULSE_W·N + 1.
- Requests while busy are not accepted (req_ready=0). req_addr is sampled only at acceptance.
- A request arriving in the same cycle as done is accepted on the following edge, since IDLE starts next cycle.
- ctl_sel_rst_n is only driven low in RST and in reset. It is high in all other states after the first full path.
- ctl_sel_inc and ctl_ena are never high simultaneously.

Decomposition:
- tt_defs.vh gains the state encodings (TT_SEL_S_*) and the default PULSE_W/SETTLE constants.
- One sub-module, tt_sel_timer:
  - loadable down-counter of width clog2(max(PULSE_W,SETTLE)+1);
  - inputs load/value;
  - output expire on the last cycle of the phase.
- The FSM and pulse counter stay in tt_sel_seq.

Test Plan (PULSE_W=2, SETTLE=4):
- Cold start, request addr 3, accepted at edge 0:
  - ctl_sel_rst_n low cycles 1–2, then high;
  - three ctl_sel_inc pulses, each 2 high/2 low, cycles 7–18;
  - done and ctl_ena high at cycle 19;
  - cur_addr=3, cur_valid=1.
- From addr 3, request addr 5:
  - ctl_ena low 2 cycles;
  - two inc pulses, no sel_rst_n low;
  - done at cycle 11;
  - cur_addr=5.
- From addr 5, request addr 2: full path with reset pulse and 2 inc pulses, done at cycle 15.
- From addr 2, request addr 2: done at cycle 1, ctl_ena never drops, zero pulses.
- Cold request addr 0: reset and release only, done at cycle 7, no inc pulses.
- Assert rst during the second INC_HI of an addr-3 request:
  - next cycle all ctl outputs at reset values;
  - no done;
  - cur_valid=0;
  - a new addr-1 request then takes the full path (done at cycle 11).

Source files
------------

// File: rtl/tt_sel_seq_pkg.sv
// tt_sel_seq_pkg
//   Shared definitions for the design-select sequencer: FSM state
//   encodings and the default phase timing constants.
package tt_sel_seq_pkg;

  // Sequencer states. Encodings are fixed so they can be probed/compared
  // from outside the block if ever needed.
  typedef enum logic [2:0] {
    TT_SEL_S_IDLE   = 3'd0,
    TT_SEL_S_RST    = 3'd1,
    TT_SEL_S_REL    = 3'd2,
    TT_SEL_S_GAP    = 3'd3,
    TT_SEL_S_INC_HI = 3'd4,
    TT_SEL_S_INC_LO = 3'd5,
    TT_SEL_S_ENA    = 3'd6
  } tt_sel_state_e;

  // Default cycles per phase (reset low, inc high, inc low, ena gap).
  localparam int TT_SEL_PULSE_W_DEF = 2;
  // Default cycles sel_rst_n is held high before the first increment.
  localparam int TT_SEL_SETTLE_DEF  = 4;

  // Width of a down-counter able to hold any phase length.
  function automatic int tt_sel_timer_width(input int pulse_w, input int settle);
    int m;
    m = (pulse_w > settle) ? pulse_w : settle;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tt_sel_seq_timer.sv
// tt_sel_timer
//   Loadable phase timer. Loading a length L makes expire go high on the
//   L-th cycle after the load edge, i.e. on the last cycle of the phase.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   load   - start a new phase on this edge
//   value  - phase length in cycles (must be >= 1)
//   expire - high during the final cycle of the current phase
module tt_sel_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count_reg;

  // The counter holds "cycles remaining after this one", so a phase of
  // length L is loaded as L-1 and expires when the count reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value - W'(1);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expire = (count_reg == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// tt_sel_seq
//   Drives the chip's design-select pads (sel_rst_n, sel_inc, ena) so that a
//   requested design address becomes selected and enabled. Tracks the
//   currently selected address so that re-selecting the same design is
//   immediate and moving to a higher address only issues the missing
//   increment pulses; anything else resets the selection counter first.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req_valid/ready - request handshake (accepted when both high)
//   req_addr        - target design address, sampled at acceptance
//   busy            - sequence in progress (after accept through done)
//   done            - one-cycle pulse when the target is enabled
//   cur_addr/valid  - last successfully selected address
//   ctl_sel_rst_n   - selection counter reset pad (active low)
//   ctl_sel_inc     - selection increment pad (rising edge counts)
//   ctl_ena         - design enable pad
module tt_sel_seq
  import tt_sel_seq_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int PULSE_W = TT_SEL_PULSE_W_DEF,
  parameter int SETTLE  = TT_SEL_SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctl_sel_rst_n,
  output logic              ctl_sel_inc,
  output logic              ctl_ena
);

  localparam int TW = tt_sel_timer_width(PULSE_W, SETTLE);
  localparam logic [TW-1:0] PULSE_V  = TW'(PULSE_W);
  localparam logic [TW-1:0] SETTLE_V = TW'(SETTLE);

  tt_sel_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] tgt_reg, tgt_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;   // increment pulses still to issue
  logic              tmr_load;
  logic [TW-1:0]     tmr_value;
  logic              tmr_expire;

  tt_sel_timer #(
    .W (TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // Next-state logic. Every phase change reloads the timer with the length
  // of the phase being entered.
  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    cnt_next   = cnt_reg;
    tmr_load   = 1'b0;
    tmr_value  = PULSE_V;

    unique case (state_reg)
      TT_SEL_S_IDLE: begin
        if (req_valid) begin
          tgt_next  = req_addr;
          tmr_load  = 1'b1;
          tmr_value = PULSE_V;
          if (cur_valid && (req_addr == cur_addr)) begin
            state_next = TT_SEL_S_ENA;
          end else if (cur_valid && (req_addr > cur_addr)) begin
            // Counter only counts up, so a higher target can be reached
            // without resetting it.
            state_next = TT_SEL_S_GAP;
            cnt_next   = req_addr - cur_addr;
          end else begin
            state_next = TT_SEL_S_RST;
            cnt_next   = req_addr;
          end
        end
      end

      TT_SEL_S_RST: begin
        if (tmr_expire) begin
          state_next = TT_SEL_S_REL;
          tmr_load   = 1'b1;
          tmr_value  = SETTLE_V;
        end
      end

      TT_SEL_S_REL, TT_SEL_S_GAP: begin
        if (tmr_expire) begin
          if (cnt_reg == '0) begin
            state_next = TT_SEL_S_ENA;
          end else begin
            state_next = TT_SEL_S_INC_HI;
            tmr_load   = 1'b1;
            tmr_value  = PULSE_V;
          end
        end
      end

      TT_SEL_S_INC_HI: begin
        if (tmr_expire) begin
          state_next = TT_SEL_S_INC_LO;
          tmr_load   = 1'b1;
          tmr_value  = PULSE_V;
        end
      end

      TT_SEL_S_INC_LO: begin
        if (tmr_expire) begin
          cnt_next = cnt_reg - ADDR_W'(1);
          // cnt_reg is never zero here: INC_HI is only entered with work left.
          if (cnt_reg == ADDR_W'(1)) begin
            state_next = TT_SEL_S_ENA;
          end else begin
            state_next = TT_SEL_S_INC_HI;
            tmr_load   = 1'b1;
            tmr_value  = PULSE_V;
          end
        end
      end

      TT_SEL_S_ENA: begin
        state_next = TT_SEL_S_IDLE;
      end

      default: begin
        state_next = TT_SEL_S_IDLE;
      end
    endcase
  end

  // All outputs are registered from the next state, so each pad waveform
  // lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= TT_SEL_S_IDLE;
      tgt_reg       <= '0;
      cnt_reg       <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      cur_addr      <= '0;
      cur_valid     <= 1'b0;
      ctl_sel_rst_n <= 1'b0;
      ctl_sel_inc   <= 1'b0;
      ctl_ena       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tgt_reg     <= tgt_next;
      cnt_reg     <= cnt_next;
      req_ready   <= (state_next == TT_SEL_S_IDLE);
      busy        <= (state_next != TT_SEL_S_IDLE);
      done        <= (state_next == TT_SEL_S_ENA);
      ctl_sel_inc <= (state_next == TT_SEL_S_INC_HI);

      // sel_rst_n and ena are sticky: they only change on entry to the
      // phases that own them, and hold everywhere else (ena stays high in
      // IDLE after a selection, sel_rst_n stays high after a release).
      unique case (state_next)
        TT_SEL_S_RST: begin
          ctl_sel_rst_n <= 1'b0;
          ctl_ena       <= 1'b0;
        end
        TT_SEL_S_REL: begin
          ctl_sel_rst_n <= 1'b1;
        end
        TT_SEL_S_GAP: begin
          ctl_ena <= 1'b0;
        end
        TT_SEL_S_ENA: begin
          ctl_ena   <= 1'b1;
          cur_addr  <= tgt_next;
          cur_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
